conv_acc_driver: RTL and testbench
==================================

# conv_acc_driver

Initiator side of the accumulator register interface in the image-convolution datapath. For each output pixel it clears the accumulator, then streams TAPS pixel/weight pairs and issues one accumulator update per accepted pair: a load of `acc_q + pixel*weight`, or an increment when the product is exactly 1. When the window is finished it presents the final sum to the write-back stage.

## Interface
Parameters:
- `PIX_W`, 8, unsigned pixel width
- `WGT_W`, 8, signed two's-complement kernel weight width
- `ACC_W`, 32, accumulator width
- `TAPS`, 9, pairs per output pixel (3x3 kernel); legal range 1..255

Ports:
- `clk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a window; sampled only in IDLE
- `pix_valid`  in  1  pixel/weight pair present
- `pix_in`  in  PIX_W  pixel value
- `wgt_in`  in  WGT_W  weight value
- `pix_ready`  out  1  pair accepted on edge where `pix_valid & pix_ready`
- `acc_q`  in  ACC_W  accumulator current value (accumulator `data_out`)
- `acc_data_out`  out  ACC_W  value to load (accumulator `data_in`)
- `acc_w_en`  out  1  accumulator load strobe
- `acc_inc`  out  1  accumulator +1 strobe
- `busy`  out  1  high in every state except IDLE
- `result`  out  ACC_W  final sum, valid with `result_valid`
- `result_valid`  out  1  one-cycle pulse

## Operation
- Accumulator contract (partner block, fixed):
  - On the rising edge, `w_en` loads `data_in`; otherwise `inc` adds 1.
  - `w_en` has priority.
  - The accumulator has no reset.
- FSM states: IDLE, CLEAR, ACCUM, DONE.
  - IDLE: `start` -> CLEAR; otherwise stay.
  - CLEAR: one cycle; `acc_w_en=1`, `acc_data_out=0`; -> ACCUM; beat counter cleared.
  - ACCUM: `pix_ready=1`. On each accepted beat:
    - Product `p = $signed({1'b0,pix_in}) * $signed(wgt_in)`, sign-extended to ACC_W.
    - If `p == 1`: `acc_inc=1`, `acc_w_en=0`.
    - Otherwise: `acc_w_en=1`, `acc_data_out = acc_q + p`.
    - Sum wraps modulo 2^ACC_W; no saturation.
    - Counter increments; the beat where counter reaches TAPS-1 moves to DONE.
  - ACCUM, no beat accepted: `acc_w_en=0`, `acc_inc=0`; stay.
  - DONE: one cycle; `result = acc_q`, `result_valid=1`, `pix_ready=0`; -> IDLE.
- `acc_w_en` and `acc_inc` are never high together.
- Outside CLEAR and accepted ACCUM beats, both strobes are low and `acc_data_out = 0`.
- `start` is ignored while `busy`.
- `result` holds its last value after DONE until the next DONE.
- `pix_valid` is ignored outside ACCUM.

## Timing
- Reset values: state IDLE, counter 0, `pix_ready=0`, `acc_w_en=0`, `acc_inc=0`, `acc_data_out=0`, `busy=0`, `result=0`, `result_valid=0`.
- `pix_ready`, `busy` and the state are registered.
- `acc_*` outputs are combinational from state, the current beat and `acc_q`.
  - The accumulator updates on the edge that accepts a beat, so `acc_q` is current on the next beat.
  - Sustains one update per cycle, back to back.
- Latency with `start` sampled at edge 0 and continuous `pix_valid`:
  - CLEAR in cycle 1.
  - ACCUM beats in cycles 2..TAPS+1.
  - DONE / `result_valid` in cycle TAPS+2 (cycle 11 for TAPS=9).
- Each cycle with `pix_valid=0` during ACCUM delays DONE by one cycle.
- `rst` in any state:
  - Next cycle is IDLE with reset output values, and no strobe is issued in that cycle.
  - Accumulator contents are left as-is; the next `start` clears them.
- `start` held high through DONE: starts a new window only after returning to IDLE, i.e. CLEAR two cycles after DONE.

## Test plan
- `pix_in=2`, `wgt_in=3` on all 9 beats, continuous valid -> `acc_w_en` high for cycles 1..10, `result=54` with `result_valid` at cycle 11.
- `pix_in=1`, `wgt_in=1` on all beats -> `acc_inc` high for 9 cycles with `acc_w_en=0` (only the CLEAR load has `acc_w_en=1`); `result=9`.
- `pix_in=255`, `wgt_in=8'h80` (-128) on all beats -> `result=32'hFFFB8480` (-293760).
- Continuous valid except 3 idle cycles after beat 4, pixels 1..9 with weights all 2 -> `result=90`, `result_valid` at cycle 14; no strobes during the gap.
- `rst` asserted for one cycle after 4 accepted beats -> following cycle `busy=0` and no strobes. A new `start` with 9 pairs (5,1) -> CLEAR writes 0, `result=45`.
- `start` pulsed during ACCUM -> ignored, exactly one `result_valid` per window.

Source files
------------

// File: rtl/conv_acc_driver.sv
// conv_acc_driver
//
// Drives the accumulator register interface for one output pixel of the
// image-convolution datapath. For each window it:
//   1. clears the accumulator,
//   2. streams TAPS pixel/weight pairs and issues one accumulator update per
//      accepted pair (a load of acc_q + pixel*weight, or a +1 strobe when the
//      product is exactly 1),
//   3. presents the final sum to the write-back stage.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - begin a window (sampled only while idle)
//   pix_valid     - pixel/weight pair present
//   pix_in        - unsigned pixel value
//   wgt_in        - signed two's-complement kernel weight
//   pix_ready     - pair accepted on an edge where pix_valid & pix_ready
//   acc_q         - accumulator current value
//   acc_data_out  - value to load into the accumulator
//   acc_w_en      - accumulator load strobe
//   acc_inc       - accumulator +1 strobe
//   busy          - high whenever a window is in progress
//   result        - final sum, valid with result_valid, held until next window
//   result_valid  - one-cycle pulse marking a finished window
module conv_acc_driver #(
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 32,
    parameter int TAPS  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [WGT_W-1:0] wgt_in,
    output logic             pix_ready,
    input  logic [ACC_W-1:0] acc_q,
    output logic [ACC_W-1:0] acc_data_out,
    output logic             acc_w_en,
    output logic             acc_inc,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product of an unsigned PIX_W value (made positive by a zero MSB) and a
    // signed WGT_W value fits exactly in PIX_W + WGT_W + 1 bits.
    localparam int              PROD_W    = PIX_W + WGT_W + 1;
    localparam logic [7:0]      LAST_BEAT = 8'(TAPS - 1);

    state_t             state_reg;
    logic [7:0]         cnt_reg;
    logic               pix_ready_reg;
    logic               busy_reg;
    logic               result_valid_reg;
    logic [ACC_W-1:0]   result_reg;

    logic signed [PROD_W-1:0] pix_ext;
    logic signed [PROD_W-1:0] wgt_ext;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_acc;
    logic                     beat;

    // Both operands widened to the full product width so the multiply is
    // a plain same-width signed multiply.
    assign pix_ext  = {{(WGT_W + 1){1'b0}}, pix_in};
    assign wgt_ext  = {{(PIX_W + 1){wgt_in[WGT_W-1]}}, wgt_in};
    assign prod     = pix_ext * wgt_ext;
    assign prod_acc = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // pix_ready is high exactly while in ACCUM, so this is the accept condition.
    assign beat = (state_reg == ACCUM) && pix_valid;

    // Accumulator strobes follow the current beat so that the accumulator
    // updates on the same edge that accepts the pair; acc_q is then already
    // up to date for the next beat, allowing back-to-back updates.
    always_comb begin
        acc_w_en     = 1'b0;
        acc_inc      = 1'b0;
        acc_data_out = '0;
        if (state_reg == CLEAR) begin
            acc_w_en = 1'b1;
        end else if (beat) begin
            if (prod_acc == ACC_W'(1)) begin
                acc_inc = 1'b1;
            end else begin
                acc_w_en     = 1'b1;
                acc_data_out = acc_q + prod_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            pix_ready_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CLEAR;
                        busy_reg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_reg       <= '0;
                    pix_ready_reg <= 1'b1;
                    state_reg     <= ACCUM;
                end
                ACCUM: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + 8'd1;
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg        <= DONE;
                            pix_ready_reg    <= 1'b0;
                            result_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The last update landed on the edge into DONE, so acc_q
                    // holds the final sum here; keep it for after the pulse.
                    result_reg <= acc_q;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pix_ready    = pix_ready_reg;
    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign result       = (state_reg == DONE) ? acc_q : result_reg;

endmodule

// File: tb/tb_conv_acc_driver.sv
// Testbench for conv_acc_driver: behavioural accumulator partner, a result
// scoreboard fed at stimulus time, and directed window sequences.
module tb_conv_acc_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic [7:0]  wgt_in;
    logic        pix_ready;
    logic [31:0] acc_q;
    logic [31:0] acc_data_out;
    logic        acc_w_en;
    logic        acc_inc;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int nchecks = 0;
    int nerrors = 0;
    int rv_count = 0;

    logic [31:0]       sb_q[$];
    logic [7:0]        pix_tab[9];
    logic signed [7:0] wgt_tab[9];

    // Accumulator partner: load has priority over increment, no reset.
    logic [31:0] acc = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (acc_w_en)     acc <= acc_data_out;
        else if (acc_inc) acc <= acc + 32'd1;
    end
    assign acc_q = acc;

    always #5 clk = ~clk;

    conv_acc_driver #(.PIX_W(8), .WGT_W(8), .ACC_W(32), .TAPS(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_in       (pix_in),
        .wgt_in       (wgt_in),
        .pix_ready    (pix_ready),
        .acc_q        (acc_q),
        .acc_data_out (acc_data_out),
        .acc_w_en     (acc_w_en),
        .acc_inc      (acc_inc),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle protocol checks and scoreboard pop on each result pulse.
    always begin
        @(negedge clk);
        #2;
        check("strobe_excl", {31'd0, acc_w_en & acc_inc}, 32'd0);
        if (!acc_w_en) check("data_when_no_load", acc_data_out, 32'd0);
        if (result_valid) begin
            rv_count++;
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [31:0] exp_r;
                exp_r = sb_q.pop_front();
                $display("result #%0d: got=%0h want=%0h", rv_count, result, exp_r);
                check("sb_result", result, exp_r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one full window from the tables. gap_at: number of accepted beats
    // after which pix_valid drops for gap_len cycles. start_at: cycle (counted
    // from CLEAR = 1) in which start is pulsed again.
    task automatic run_window(input string name, input int gap_at, input int gap_len,
                              input int start_at, output int done_cyc,
                              output int wcnt, output int icnt);
        int b, gap_left, cyc, s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(pix_tab[i]) * int'(wgt_tab[i]);
        sb_q.push_back(32'(s));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = pix_tab[0];
        wgt_in    = wgt_tab[0];
        #1;
        check({name, "/clear_wen"}, {31'd0, acc_w_en}, 32'd1);
        check({name, "/clear_data"}, acc_data_out, 32'd0);
        check({name, "/clear_busy"}, {31'd0, busy}, 32'd1);
        check({name, "/clear_ready"}, {31'd0, pix_ready}, 32'd0);
        b = 0; gap_left = gap_len; cyc = 1; done_cyc = -1; wcnt = 0; icnt = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (cyc == start_at);
            if (result_valid) begin
                done_cyc = cyc;
                break;
            end
            if (b == gap_at && gap_left > 0) begin
                pix_valid = 1'b0;
                gap_left--;
            end else if (b < 9) begin
                pix_valid = 1'b1;
                pix_in    = pix_tab[b];
                wgt_in    = wgt_tab[b];
            end else begin
                pix_valid = 1'b0;
            end
            #1;
            if (acc_w_en) wcnt++;
            if (acc_inc)  icnt++;
            if (pix_valid && pix_ready) b++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        $display("window %s: done_cycle=%0d loads=%0d incs=%0d", name, done_cyc, wcnt, icnt);
    endtask

    task automatic fill(input logic [7:0] p, input logic [7:0] w);
        for (int i = 0; i < 9; i++) begin
            pix_tab[i] = p;
            wgt_tab[i] = w;
        end
    endtask

    initial begin
        int d, wc, ic;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0; wgt_in = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/ready", {31'd0, pix_ready}, 32'd0);
        check("reset/rv", {31'd0, result_valid}, 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/wen", {31'd0, acc_w_en}, 32'd0);
        check("reset/inc", {31'd0, acc_inc}, 32'd0);
        check("reset/data", acc_data_out, 32'd0);
        rst = 1'b0;

        // 2*3 on every beat
        fill(8'd2, 8'd3);
        run_window("t1", -1, 0, -1, d, wc, ic);
        check("t1/done_cycle", 32'(d), 32'd11);
        check("t1/loads", 32'(wc), 32'd9);
        check("t1/incs", 32'(ic), 32'd0);
        check("t1/result", result, 32'd54);

        // product 1 -> increments only
        fill(8'd1, 8'd1);
        run_window("t2", -1, 0, -1, d, wc, ic);
        check("t2/done_cycle", 32'(d), 32'd11);
        check("t2/loads", 32'(wc), 32'd0);
        check("t2/incs", 32'(ic), 32'd9);
        check("t2/result", result, 32'd9);

        // most negative product
        fill(8'd255, 8'h80);
        run_window("t3", -1, 0, -1, d, wc, ic);
        check("t3/result", result, 32'hFFFB8480);

        // 3-cycle gap after beat 4
        for (int i = 0; i < 9; i++) begin
            pix_tab[i] = 8'(i + 1);
            wgt_tab[i] = 8'sd2;
        end
        run_window("t4", 4, 3, -1, d, wc, ic);
        check("t4/done_cycle", 32'(d), 32'd14);
        check("t4/loads", 32'(wc), 32'd9);
        check("t4/result", result, 32'd90);

        // reset after 4 accepted beats of 3*2
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; pix_valid = 1'b1; pix_in = 8'd3; wgt_in = 8'd2;
        repeat (5) @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0;
        #1;
        check("rst/busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst/busy", {31'd0, busy}, 32'd0);
        check("rst/ready", {31'd0, pix_ready}, 32'd0);
        check("rst/wen", {31'd0, acc_w_en}, 32'd0);
        check("rst/inc", {31'd0, acc_inc}, 32'd0);
        check("rst/rv", {31'd0, result_valid}, 32'd0);
        check("rst/acc_kept", acc, 32'd24);
        fill(8'd5, 8'd1);
        run_window("t5", -1, 0, -1, d, wc, ic);
        check("t5/result", result, 32'd45);

        // start pulsed mid-ACCUM must be ignored
        fill(8'd4, 8'hFF);
        run_window("t6", -1, 0, 5, d, wc, ic);
        check("t6/done_cycle", 32'(d), 32'd11);
        check("t6/result", result, 32'hFFFFFFDC);
        repeat (4) @(negedge clk);
        #1;
        check("t6/idle_busy", {31'd0, busy}, 32'd0);
        check("t6/rv_count", 32'(rv_count), 32'd6);

        // random pairs against the scoreboard model
        for (int i = 0; i < 9; i++) begin
            pix_tab[i] = 8'($urandom_range(0, 255));
            wgt_tab[i] = 8'($urandom_range(0, 255));
        end
        run_window("t7", -1, 0, -1, d, wc, ic);
        check("t7/done_cycle", 32'(d), 32'd11);

        repeat (4) @(negedge clk);
        #3;
        check("end/rv_count", 32'(rv_count), 32'd7);
        check("end/sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
